signal_light_ctrl: RTL

Two-road intersection phase scheduler that drives the main-road (light1) and side-road (light2) lamps plus a phase countdown. The main road rests in green. Side-road vehicle-sensor and pedestrian requests are latched and served after a minimum main-green time. An emergency input pre-empts to all-red through the yellow phases. Timing advances on a one-cycle tick enable, so the block can run from a prescaled time base.

---
 rtl/signal_light_if.sv | 28 ++
 rtl/signal_light_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/signal_light_if.sv
// Lamp/request bundle between the intersection scheduler and its environment.
// The master side drives the time base and requests, and the slave side (the
// scheduler) drives the lamps and status.
interface signal_light_if #(
  parameter int unsigned CW = 6
) ();

  logic          tick;
  logic          side_req;
  logic          ped_req;
  logic          emerg;
  logic [2:0]    light1;
  logic [2:0]    light2;
  logic [CW-1:0] count;
  logic          pend;
  logic [2:0]    phase;

  modport master (
    output tick, side_req, ped_req, emerg,
    input  light1, light2, count, pend, phase
  );

  modport slave (
    input  tick, side_req, ped_req, emerg,
    output light1, light2, count, pend, phase
  );

endinterface

// File: rtl/signal_light_ctrl.sv
// Two-road intersection phase scheduler. The main road rests in green. Side-road
// and pedestrian requests are latched and served after the minimum main green.
// Emergency pre-empt reaches all-red through the yellow phases. All phase timing
// advances only on tick, so the block can run from a prescaled time base.
module signal_light_ctrl #(
  parameter int unsigned MAIN_MIN = 20,
  parameter int unsigned MAIN_Y   = 3,
  parameter int unsigned ALL_R    = 2,
  parameter int unsigned SIDE_G   = 10,
  parameter int unsigned SIDE_Y   = 3,
  parameter int unsigned CW       = 6
) (
  input logic           clk,
  input logic           rst,
  signal_light_if.slave bus
);

  typedef enum logic [2:0] {
    StMainG = 3'd0,
    StMainY = 3'd1,
    StAllR1 = 3'd2,
    StSideG = 3'd3,
    StSideY = 3'd4,
    StAllR2 = 3'd5,
    StEmerg = 3'd6
  } state_e;

  // Count is loaded with duration-1 on phase entry, so it reads 0 in the last tick.
  localparam logic [CW-1:0] LdMainG = CW'(MAIN_MIN - 1);
  localparam logic [CW-1:0] LdMainY = CW'(MAIN_Y - 1);
  localparam logic [CW-1:0] LdAllR  = CW'(ALL_R - 1);
  localparam logic [CW-1:0] LdSideG = CW'(SIDE_G - 1);
  localparam logic [CW-1:0] LdSideY = CW'(SIDE_Y - 1);

  state_e        state_q;
  state_e        nxt;
  logic [CW-1:0] count_q;
  logic [CW-1:0] ld;
  logic          pend_q;
  logic          go;
  logic          cnt_zero;
  logic          illegal;
  logic          enter_side;

  assign cnt_zero = (count_q == '0);

  // Transition decode: the phase the current one leads to, and whether it leaves on a tick.
  always_comb begin
    nxt     = StMainG;
    go      = 1'b0;
    illegal = 1'b0;
    case (state_q)
      StMainG: begin
        // Emergency cuts the main green short; otherwise rest here until a request is latched.
        nxt = StMainY;
        go  = bus.emerg | (cnt_zero & pend_q);
      end
      StMainY: begin
        nxt = StAllR1;
        go  = cnt_zero;
      end
      StAllR1: begin
        nxt = bus.emerg ? StEmerg : StSideG;
        go  = cnt_zero;
      end
      StSideG: begin
        nxt = StSideY;
        go  = bus.emerg | cnt_zero;
      end
      StSideY: begin
        nxt = StAllR2;
        go  = cnt_zero;
      end
      StAllR2: begin
        nxt = bus.emerg ? StEmerg : StMainG;
        go  = cnt_zero;
      end
      StEmerg: begin
        nxt = StAllR2;
        go  = ~bus.emerg;
      end
      default: begin
        nxt     = StMainG;
        illegal = 1'b1;
      end
    endcase
  end

  // Count reload value for the phase being entered; emergency parks at zero.
  always_comb begin
    ld = '0;
    case (nxt)
      StMainG: ld = LdMainG;
      StMainY: ld = LdMainY;
      StAllR1: ld = LdAllR;
      StSideG: ld = LdSideG;
      StSideY: ld = LdSideY;
      StAllR2: ld = LdAllR;
      StEmerg: ld = '0;
      default: ld = '0;
    endcase
  end

  // The edge that enters side green serves every request latched so far.
  assign enter_side = bus.tick & go & ~illegal & (nxt == StSideG);

  // Phase sequencer: state and countdown move only on tick; an illegal code recovers at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StMainG;
      count_q <= LdMainG;
    end else if (illegal) begin
      state_q <= StMainG;
      count_q <= LdMainG;
    end else if (bus.tick) begin
      if (go) begin
        state_q <= nxt;
        count_q <= ld;
      end else if (!cnt_zero) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  // Request latch: samples on every edge, not tick-gated; a request coinciding with side-green
  // entry is dropped because that green serves it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= 1'b0;
    end else if (enter_side) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_q | bus.side_req | bus.ped_req;
    end
  end

  // Lamp decode from the state register; anything unexpected shows all-red.
  always_comb begin
    bus.light1 = 3'b100;
    bus.light2 = 3'b100;
    case (state_q)
      StMainG: bus.light1 = 3'b001;
      StMainY: bus.light1 = 3'b010;
      StSideG: bus.light2 = 3'b001;
      StSideY: bus.light2 = 3'b010;
      default: begin
        bus.light1 = 3'b100;
        bus.light2 = 3'b100;
      end
    endcase
  end

  assign bus.count = count_q;
  assign bus.pend  = pend_q;
  assign bus.phase = state_q;

endmodule
